// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, FSM state type and error-count width for the 7-segment decoder
package seg7_pkg;

    localparam int ERR_CNT_W = 8;

    // Active-low patterns, bit0=a .. bit6=g
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        HOLD   = 2'd2
    } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to hex digit lookup
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'h0;
        valid = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - debounced 7-segment sampler assembling NUM_DIGITS hex digits into a value
// Optional saturating error counter enabled by SEG7_DEC_ERRCNT_EN.
module seg7_hex_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                iSEG,
    input  logic                      iSEG_VALID,
    input  logic                      iREADY,
    output logic [3:0]                oDIG,
    output logic                      oDIG_VALID,
    output logic [4*NUM_DIGITS-1:0]   oVALUE,
    output logic                      oVALUE_VALID,
    output logic                      oERR,
    output logic [ERR_CNT_W-1:0]      oERR_CNT
);

    localparam int VW = 4 * NUM_DIGITS;

    seg7_state_t     state, nxt_state;
    logic [6:0]      cap, nxt_cap;
    logic [7:0]      cnt, nxt_cnt;
    logic [3:0]      ndig, nxt_ndig;
    logic [3:0]      dig_r, nxt_dig;
    logic            dig_valid_r, nxt_dig_valid;
    logic [VW-1:0]   value_r, nxt_value;
    logic            vvalid_r, nxt_vvalid;
    logic            err_r, nxt_err;
    logic            start_run;
    logic            accept;
    logic            capture_ok;
    logic [3:0]      dec_digit;
    logic            dec_valid;

    seg7_pattern_decode u_decode (
        .pattern (iSEG),
        .digit   (dec_digit),
        .valid   (dec_valid)
    );

    // A completed value freezes the sampler until the consumer takes it
    assign capture_ok = !vvalid_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cap         <= 7'h00;
            cnt         <= 8'd0;
            ndig        <= 4'd0;
            dig_r       <= 4'd0;
            dig_valid_r <= 1'b0;
            value_r     <= '0;
            vvalid_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state       <= nxt_state;
            cap         <= nxt_cap;
            cnt         <= nxt_cnt;
            ndig        <= nxt_ndig;
            dig_r       <= nxt_dig;
            dig_valid_r <= nxt_dig_valid;
            value_r     <= nxt_value;
            vvalid_r    <= nxt_vvalid;
            err_r       <= nxt_err;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_cap       = cap;
        nxt_cnt       = cnt;
        nxt_ndig      = ndig;
        nxt_dig       = dig_r;
        nxt_dig_valid = 1'b0;
        nxt_value     = value_r;
        nxt_vvalid    = vvalid_r;
        nxt_err       = 1'b0;
        start_run     = 1'b0;
        accept        = 1'b0;

        if (vvalid_r && iREADY) begin
            nxt_vvalid = 1'b0;
            nxt_value  = '0;
            nxt_ndig   = 4'd0;
        end

        case (state)
            IDLE: begin
                if (iSEG_VALID && capture_ok) begin
                    start_run = 1'b1;
                end
            end
            STABLE: begin
                if (!iSEG_VALID) begin
                    nxt_state = IDLE;
                end else if (iSEG != cap) begin
                    start_run = 1'b1;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                    if ({1'b0, cnt} + 9'd1 == 9'(STABLE_CYCLES)) begin
                        accept    = 1'b1;
                        nxt_state = HOLD;
                    end
                end
            end
            HOLD: begin
                // A blocked change drops to IDLE so the new pattern is counted fresh later
                if (!iSEG_VALID) begin
                    nxt_state = IDLE;
                end else if (iSEG != cap) begin
                    if (capture_ok) begin
                        start_run = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase

        if (start_run) begin
            nxt_cap = iSEG;
            nxt_cnt = 8'd1;
            if (STABLE_CYCLES == 1) begin
                accept    = 1'b1;
                nxt_state = HOLD;
            end else begin
                nxt_state = STABLE;
            end
        end

        // The accepted pattern always equals iSEG on the accepting edge
        if (accept) begin
            if (dec_valid) begin
                nxt_dig       = dec_digit;
                nxt_dig_valid = 1'b1;
                nxt_value     = (value_r << 4) | VW'(dec_digit);
                nxt_ndig      = ndig + 4'd1;
                if (ndig + 4'd1 == 4'(NUM_DIGITS)) begin
                    nxt_vvalid = 1'b1;
                end
            end else begin
                nxt_err   = 1'b1;
                nxt_value = '0;
                nxt_ndig  = 4'd0;
            end
        end
    end

    assign oDIG         = dig_r;
    assign oDIG_VALID   = dig_valid_r;
    assign oVALUE       = value_r;
    assign oVALUE_VALID = vvalid_r;
    assign oERR         = err_r;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (nxt_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign oERR_CNT = err_cnt;
`else
    assign oERR_CNT = '0;
`endif

endmodule

// File: tb/tb_seg7_hex_decoder.sv
// tb/tb_seg7_hex_decoder.sv - randomized and directed self-check of seg7_hex_decoder against a run-length reference model
module tb_seg7_hex_decoder;

    localparam int SC = 4;
    localparam int ND = 4;
    localparam int VW = 4 * ND;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg = 7'h7F;
    logic          seg_valid = 1'b0;
    logic          ready = 1'b0;
    logic [3:0]    dig;
    logic          dig_valid;
    logic [VW-1:0] value;
    logic          value_valid;
    logic          err;
    logic [7:0]    err_cnt;

    seg7_hex_decoder #(.STABLE_CYCLES(SC), .NUM_DIGITS(ND)) dut (
        .clk          (clk),
        .rst          (rst),
        .iSEG         (seg),
        .iSEG_VALID   (seg_valid),
        .iREADY       (ready),
        .oDIG         (dig),
        .oDIG_VALID   (dig_valid),
        .oVALUE       (value),
        .oVALUE_VALID (value_valid),
        .oERR         (err),
        .oERR_CNT     (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    logic [6:0] table_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (table_pat[i] == p) return i;
        return -1;
    endfunction

    // Reference: a "run" is a stretch of identical valid samples; each run may yield one accept
    int          m_dig, m_ndig, m_errcnt;
    bit          m_dig_valid, m_vvalid, m_err;
    int unsigned m_value;
    bit          run_active, run_done;
    logic [6:0]  run_pat;
    int          run_len;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dig = 0; m_ndig = 0; m_errcnt = 0; m_value = 0;
            m_dig_valid = 0; m_vvalid = 0; m_err = 0;
            run_active = 0; run_done = 0; run_len = 0; run_pat = 7'h00;
        end else begin
            bit blocked;
            blocked     = m_vvalid;
            m_dig_valid = 0;
            m_err       = 0;
            if (m_vvalid && ready) begin
                m_vvalid = 0; m_value = 0; m_ndig = 0;
            end
            if (!seg_valid) begin
                run_active = 0;
            end else if (blocked) begin
                if (!(run_active && run_done && seg == run_pat)) run_active = 0;
            end else begin
                if (run_active && seg == run_pat) run_len++;
                else begin
                    run_active = 1; run_pat = seg; run_len = 1; run_done = 0;
                end
                if (!run_done && run_len >= SC) begin
                    int d;
                    run_done = 1;
                    d = lookup(seg);
                    if (d >= 0) begin
                        m_dig = d; m_dig_valid = 1;
                        m_value = ((m_value * 16) + d) % (1 << VW);
                        m_ndig++;
                        if (m_ndig == ND) m_vvalid = 1;
                    end else begin
                        m_err = 1; m_value = 0; m_ndig = 0;
`ifdef SEG7_DEC_ERRCNT_EN
                        if (m_errcnt < 255) m_errcnt++;
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("dig",         32'(dig),         32'(m_dig));
            check_eq("dig_valid",   32'(dig_valid),   32'(m_dig_valid));
            check_eq("value",       32'(value),       m_value);
            check_eq("value_valid", 32'(value_valid), 32'(m_vvalid));
            check_eq("err",         32'(err),         32'(m_err));
            check_eq("err_cnt",     32'(err_cnt),     32'(m_errcnt));
        end
    end

    task automatic drive(input logic [6:0] s, input logic v, input int n);
        seg = s;
        seg_valid = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_dig"},    32'(dig),         32'd0);
        check_eq({tag, "_dv"},     32'(dig_valid),   32'd0);
        check_eq({tag, "_val"},    32'(value),       32'd0);
        check_eq({tag, "_vv"},     32'(value_valid), 32'd0);
        check_eq({tag, "_err"},    32'(err),         32'd0);
        check_eq({tag, "_errcnt"}, 32'(err_cnt),     32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [6:0] pool [19];
        for (int i = 0; i < 16; i++) pool[i] = table_pat[i];
        pool[16] = 7'h7F; pool[17] = 7'h55; pool[18] = 7'h2A;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_eq("reset_value", 32'(value), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Steady pattern gives exactly one accept
        seg = 7'h12; seg_valid = 1'b1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dig_valid) begin
                pulses++;
                check_eq("hold5_cycle", 32'(i), 32'd3);
            end
        end
        check_eq("hold5_pulses", 32'(pulses), 32'd1);
        check_eq("hold5_dig", 32'(dig), 32'd5);
        drive(7'h00, 1'b0, 1);

        // Short run then longer run: only the longer one is accepted
        drive(7'h40, 1'b1, 3);
        drive(7'h00, 1'b1, 4);
        check_eq("short_run_dig", 32'(dig), 32'd8);
        async_reset("rst_a");

        // Four digits assemble into a held value
        ready = 1'b0;
        drive(7'h79, 1'b1, 4);
        drive(7'h24, 1'b1, 4);
        drive(7'h30, 1'b1, 4);
        drive(7'h19, 1'b1, 4);
        check_eq("asm_value", 32'(value), 32'h1234);
        check_eq("asm_vv", 32'(value_valid), 32'd1);
        drive(7'h40, 1'b1, 6);
        check_eq("asm_held", 32'(value), 32'h1234);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_eq("asm_cleared", 32'(value), 32'd0);
        check_eq("asm_vv_clr", 32'(value_valid), 32'd0);
        drive(7'h00, 1'b0, 1);

        // Invalid pattern discards a partial value
        drive(7'h79, 1'b1, 4);
        drive(7'h24, 1'b1, 4);
        drive(7'h7F, 1'b1, 4);
        check_eq("inv_value", 32'(value), 32'd0);
`ifdef SEG7_DEC_ERRCNT_EN
        check_eq("inv_errcnt", 32'(err_cnt), 32'd1);
`else
        check_eq("inv_errcnt", 32'(err_cnt), 32'd0);
`endif

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            ready = ($urandom_range(0, 9) < 3);
            drive(pool[$urandom_range(0, 18)], ($urandom_range(0, 9) != 0), $urandom_range(1, 6));
        end

        // Reset mid-STABLE and with a pending value
        drive(7'h12, 1'b1, 2);
        async_reset("rst_stable");
        ready = 1'b0;
        drive(7'h79, 1'b1, 4);
        drive(7'h24, 1'b1, 4);
        drive(7'h30, 1'b1, 4);
        drive(7'h19, 1'b1, 4);
        check_eq("pend_vv", 32'(value_valid), 32'd1);
        async_reset("rst_pending");

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            drive(7'h7F, 1'b1, 4);
            drive(7'h7F, 1'b0, 1);
        end
`ifdef SEG7_DEC_ERRCNT_EN
        check_eq("errcnt_sat", 32'(err_cnt), 32'd255);
`else
        check_eq("errcnt_sat", 32'(err_cnt), 32'd0);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_hex_decoder.md
SEG7_HEX_DECODER -- requirements
Module: seg7_hex_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive matching samples needed to accept a pattern (legal 1..255).
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the number of digits assembled per value (legal 1..8).
REQ-003 Port clk, in, 1: SHALL be the sole clock; all state updates on rising edge.
REQ-004 Port rst, in, 1: reset SHALL be asynchronous and active-high.
REQ-005 Port iSEG, in, 7: SHALL carry an active-low segment pattern, bit0=a .. bit6=g.
REQ-006 Port iSEG_VALID, in, 1: SHALL qualify iSEG; level-sensitive.
REQ-007 Port iREADY, in, 1: SHALL be the consumer ready for oVALUE.
REQ-008 Port oDIG, out, 4: SHALL hold the last accepted digit.
REQ-009 Port oDIG_VALID, out, 1: SHALL pulse one cycle per accepted digit.
REQ-010 Port oVALUE, out, 4*NUM_DIGITS: SHALL hold the assembled digits, oldest in the MS nibble.
REQ-011 Port oVALUE_VALID, out, 1: SHALL flag oVALUE complete; held until handshake.
REQ-012 Port oERR, out, 1: SHALL pulse one cycle per accepted invalid pattern.
REQ-013 Port oERR_CNT, out, 8: SHALL report the invalid-pattern count (see Configuration).

Function
REQ-014 Decode table (hex, pattern->digit) SHALL be 40:0 79:1 24:2 30:3 19:4 12:5 02:6 78:7 00:8 18:9 08:A 03:B 46:C 21:D 06:E 0E:F; all other patterns invalid.
REQ-015 FSM states SHALL be IDLE, STABLE, HOLD.
REQ-016 IDLE: on iSEG_VALID=1 and oVALUE_VALID=0 SHALL capture iSEG, set sample count to 1, go to STABLE (STABLE_CYCLES=1: accept immediately, go to HOLD).
REQ-017 STABLE: iSEG_VALID=0 SHALL return to IDLE; iSEG differing from the captured pattern SHALL recapture and set count to 1; a match SHALL increment count.
REQ-018 When count reaches STABLE_CYCLES, the pattern SHALL be accepted and the FSM SHALL go to HOLD.
REQ-019 oDIG_VALID (valid pattern) or oERR (invalid pattern) SHALL be high in the cycle after the STABLE_CYCLES-th consecutive matching sample edge.
REQ-020 HOLD: SHALL stay until iSEG_VALID=0 (to IDLE) or iSEG changes (recapture, count 1, to STABLE); a held pattern SHALL never be accepted twice.
REQ-021 A valid accept SHALL update oDIG, shift {oVALUE, digit} left by 4 and increment the digit count.
REQ-022 When the digit count reaches NUM_DIGITS, oVALUE_VALID SHALL rise on the same edge as that digit's oDIG_VALID.
REQ-023 While oVALUE_VALID=1 and iREADY=0, no new capture SHALL occur and oVALUE SHALL be stable.
REQ-024 Handshake oVALUE_VALID=1 and iREADY=1 SHALL clear oVALUE_VALID, oVALUE and digit count on the next edge.
REQ-025 An invalid accept SHALL clear oVALUE and digit count (partial value discarded).

Reset
REQ-026 rst=1 SHALL immediately force state IDLE and all counts to 0; oDIG=0, oDIG_VALID=0, oVALUE=0, oVALUE_VALID=0, oERR=0, oERR_CNT=0.
REQ-027 Reset mid-assembly or with oVALUE_VALID pending SHALL discard all data; the first sample edge after rst deasserts SHALL behave as IDLE.

Configuration
REQ-028 With SEG7_DEC_ERRCNT_EN defined, oERR_CNT SHALL increment on every oERR pulse, saturate at 255, and clear only on reset.
REQ-029 Without SEG7_DEC_ERRCNT_EN, oERR_CNT SHALL be tied to 0 and no counter logic SHALL be built; oERR is unaffected.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16 segment-pattern constants, the FSM state enum and the 8-bit error-count width.
REQ-031 Combinational sub-module seg7_pattern_decode (pattern in; digit, valid out) SHALL implement the decode table.

Verification (STABLE_CYCLES=4, NUM_DIGITS=4)
REQ-032 Hold iSEG=7'h12 with iSEG_VALID=1 for 10 cycles -> exactly one oDIG_VALID pulse, oDIG=5, on the cycle after the 4th sample edge.
REQ-033 Present 7'h79, 7'h24, 7'h30, 7'h19, each for 4 cycles with iSEG_VALID=1, iREADY=0 -> oVALUE=16'h1234 and oVALUE_VALID=1, held; further patterns ignored until iREADY=1, then oVALUE=0 next cycle.
REQ-034 Present 7'h40 for 3 cycles, then 7'h00 for 4 -> one accept only, oDIG=8.
REQ-035 After 2 valid digits, present 7'h7F for 4 cycles -> oERR pulse, oVALUE=0, oERR_CNT=1 with macro, 0 without.
REQ-036 Assert rst mid-STABLE and during pending oVALUE_VALID -> all outputs 0 immediately; 300 invalid accepts with macro -> oERR_CNT=255.
